// File: rtl/f_u_div_pkg.sv
// Shared definitions for the sequential restoring divider family.
package f_u_div_pkg;

  localparam int unsigned DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/f_u_div_step.sv
// One restoring-division step: (N+1)-bit ripple-borrow subtract of {0,b} from t,
// keeping t when the subtraction borrows.
module f_u_div_step #(
  parameter int unsigned N = 8
) (
  input  logic [N:0]   t_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   rem_o,
  output logic         qbit_o
);

  logic [N:0]   bb;
  logic [N:0]   diff;
  logic [N+1:0] bor;

  assign bb     = {1'b0, b_i};
  assign bor[0] = 1'b0;

  for (genvar i = 0; i <= N; i++) begin : g_fs
    assign diff[i]  = t_i[i] ^ bb[i] ^ bor[i];
    assign bor[i+1] = (~t_i[i] & bb[i]) | (~(t_i[i] ^ bb[i]) & bor[i]);
  end

  assign qbit_o = ~bor[N+1];
  assign rem_o  = qbit_o ? diff : t_i;

endmodule

// File: rtl/f_u_seqdiv8.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on operands and result.
module f_u_seqdiv8
  import f_u_div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int unsigned CW = (clog2(N) > 0) ? clog2(N) : 1;

  div_state_e    state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    step_t;
  logic [N:0]    step_rem;
  logic          step_qbit;
  logic          rem_msb_unused;

  // Dividend register doubles as the quotient register: quotient bits enter at
  // the lsb as dividend bits leave at the msb.
  assign step_t = {rem_q[N-1:0], dvd_q[N-1]};

  f_u_div_step #(.N(N)) u_step (
    .t_i    (step_t),
    .b_i    (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = CW'(N - 1);
          dbz_d   = (b == '0);
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[N-2:0], step_qbit};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit N of the partial remainder is always zero once the division completes.
  assign rem_msb_unused = rem_q[N];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = dvd_q;
  assign r         = rem_q[N-1:0];
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_f_u_seqdiv8.sv
// Directed and randomised bench for the sequential restoring divider.
module tb_f_u_seqdiv8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic [7:0] r;
  logic       dbz;

  int vectors     = 0;
  int miscompares = 0;

  f_u_seqdiv8 #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency counts clock edges from the accepting edge up to the one that
  // raises out_valid: N RUN steps plus the accepting edge = 9.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int stall, input bit poke);
    int lat;
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (poke) begin
        in_valid = 1'b1;
        a        = 8'd3;
        b        = 8'd1;
      end
      tick();
      in_valid = 1'b0;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " q"}, 32'(q), 32'(eq));
    check({tag, " r"}, 32'(r), 32'(er));
    check({tag, " dbz"}, 32'(dbz), 32'(edbz));
    check({tag, " in_ready done"}, 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        a        = 8'd3;
        b        = 8'd1;
      end
      tick();
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold q"}, 32'(q), 32'(eq));
      check({tag, " hold r"}, 32'(r), 32'(er));
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] eq;
    logic [7:0] er;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset q", 32'(q), 32'd0);
    check("reset r", 32'(r), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("200/7",   8'd200, 8'd7,  8'd28,  8'd4,   1'b0, 0, 1'b0);
    run_op("255/1",   8'd255, 8'd1,  8'd255, 8'd0,   1'b0, 0, 1'b0);
    run_op("5/9",     8'd5,   8'd9,  8'd0,   8'd5,   1'b0, 1, 1'b0);
    run_op("13/13",   8'd13,  8'd13, 8'd1,   8'd0,   1'b0, 0, 1'b0);
    run_op("100/0",   8'd100, 8'd0,  8'd255, 8'd100, 1'b1, 2, 1'b0);
    run_op("77/5 bp", 8'd77,  8'd5,  8'd15,  8'd2,   1'b0, 6, 1'b1);
    run_op("0/255",   8'd0,   8'd255, 8'd0,  8'd0,   1'b0, 0, 1'b0);
    run_op("254/255", 8'd254, 8'd255, 8'd0,  8'd254, 1'b0, 0, 1'b0);
    run_op("255/255", 8'd255, 8'd255, 8'd1,  8'd0,   1'b0, 0, 1'b0);
    run_op("255/2",   8'd255, 8'd2,  8'd127, 8'd1,   1'b0, 0, 1'b0);

    // Asynchronous reset part way through a division, between clock edges.
    a         = 8'd200;
    b         = 8'd7;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst q", 32'(q), 32'd0);
    check("midrst r", 32'(r), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    run_op("9/2 after rst", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 2500; i++) begin
      ra = 8'($urandom);
      rb = (i % 16 == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0) begin
        eq = 8'd255;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run_op("sweep", ra, rb, eq, er, (rb == 8'd0), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
